// File: rtl/xilinx_sc_mixed_width_dp_ram.sv
// rtl/xilinx_sc_mixed_width_dp_ram.sv - single-clock mixed-width true dual-port RAM, pipelined reads
// Optional registered write-write overlap flag: XIL_RAM_COLLISION_FLAG_EN
module xilinx_sc_mixed_width_dp_ram #(
    parameter int C_RAM_A_WIDTH = 16,
    parameter int C_RAM_A_DEPTH = 1024,
    parameter int C_RATIO       = 2,
    parameter int C_RD_LATENCY  = 1,
    localparam int C_RAM_B_WIDTH = C_RAM_A_WIDTH * C_RATIO,
    localparam int C_RAM_B_DEPTH = C_RAM_A_DEPTH / C_RATIO,
    localparam int A_AW          = $clog2(C_RAM_A_DEPTH),
    localparam int B_AW          = (C_RAM_B_DEPTH > 1) ? $clog2(C_RAM_B_DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [A_AW-1:0]          addrA,
    input  logic                     wrenA,
    input  logic [C_RAM_A_WIDTH-1:0] dinA,
    input  logic                     rdenA,
    output logic [C_RAM_A_WIDTH-1:0] doutA,
    output logic                     rvalidA,
    input  logic [B_AW-1:0]          addrB,
    input  logic                     wrenB,
    input  logic [C_RATIO-1:0]       wrmaskB,
    input  logic [C_RAM_B_WIDTH-1:0] dinB,
    input  logic                     rdenB,
    output logic [C_RAM_B_WIDTH-1:0] doutB,
    output logic                     rvalidB,
    output logic                     collision
);

    localparam int LG_R = $clog2(C_RATIO);

    logic [C_RAM_A_WIDTH-1:0] mem_q [C_RAM_A_DEPTH];
    logic [A_AW-1:0]          base_b;
    logic [C_RAM_B_WIDTH-1:0] rdata_b;
    logic                     rd_issue_a;
    logic                     rd_issue_b;

    logic [C_RD_LATENCY-1:0]  va_q;
    logic [C_RD_LATENCY-1:0]  vb_q;
    logic [C_RAM_A_WIDTH-1:0] da_q [C_RD_LATENCY];
    logic [C_RAM_B_WIDTH-1:0] db_q [C_RD_LATENCY];

    // Port B word addrB covers A-words addrB*C_RATIO .. +C_RATIO-1, lane 0 lowest.
    assign base_b     = A_AW'(addrB) << LG_R;
    assign rd_issue_a = rdenA && !wrenA;
    assign rd_issue_b = rdenB && !wrenB;

    always_comb begin
        rdata_b = '0;
        for (int i = 0; i < C_RATIO; i++) begin
            rdata_b[i*C_RAM_A_WIDTH +: C_RAM_A_WIDTH] = mem_q[base_b | A_AW'(i)];
        end
    end

    // Port A is written last so it wins any lane both ports hit this cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wrenB) begin
                for (int i = 0; i < C_RATIO; i++) begin
                    if (wrmaskB[i]) begin
                        mem_q[base_b | A_AW'(i)] <= dinB[i*C_RAM_A_WIDTH +: C_RAM_A_WIDTH];
                    end
                end
            end
            if (wrenA) begin
                mem_q[addrA] <= dinA;
            end
        end
    end

    // Data stages only load behind a valid, so the last stage holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            va_q <= '0;
            vb_q <= '0;
            for (int i = 0; i < C_RD_LATENCY; i++) begin
                da_q[i] <= '0;
                db_q[i] <= '0;
            end
        end else begin
            va_q[0] <= rd_issue_a;
            vb_q[0] <= rd_issue_b;
            if (rd_issue_a) begin
                da_q[0] <= mem_q[addrA];
            end
            if (rd_issue_b) begin
                db_q[0] <= rdata_b;
            end
            for (int i = 1; i < C_RD_LATENCY; i++) begin
                va_q[i] <= va_q[i-1];
                vb_q[i] <= vb_q[i-1];
                if (va_q[i-1]) begin
                    da_q[i] <= da_q[i-1];
                end
                if (vb_q[i-1]) begin
                    db_q[i] <= db_q[i-1];
                end
            end
        end
    end

    assign doutA   = da_q[C_RD_LATENCY-1];
    assign rvalidA = va_q[C_RD_LATENCY-1];
    assign doutB   = db_q[C_RD_LATENCY-1];
    assign rvalidB = vb_q[C_RD_LATENCY-1];

`ifdef XIL_RAM_COLLISION_FLAG_EN
    logic coll_hit;
    logic collision_q;

    always_comb begin
        coll_hit = 1'b0;
        for (int i = 0; i < C_RATIO; i++) begin
            if (wrmaskB[i] && ((base_b | A_AW'(i)) == addrA)) begin
                coll_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= wrenA && wrenB && coll_hit;
        end
    end

    assign collision = collision_q;
`else
    assign collision = 1'b0;
`endif

endmodule
